// File: rtl/v_result_reader.sv
// V vector read-out engine: sweeps the four V SRAM banks in global element
// order and streams each complex word on a valid/ready interface. A 2-entry
// FIFO plus a 1-deep in-flight register bound the outstanding reads so that
// backpressure never drops an SRAM read.
module v_result_reader #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 48,
  parameter int unsigned IDX_W     = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W:0]    num_elems,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data_1,
  input  logic [DATA_W-1:0] rd_data_2,
  input  logic [DATA_W-1:0] rd_data_3,
  input  logic [DATA_W-1:0] rd_data_4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SEL_W = $clog2(NUM_BANKS);
  localparam logic [IDX_W:0] MaxN = {1'b1, {IDX_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              r_state, w_state_next;
  logic [IDX_W:0]      r_n;
  logic [IDX_W-1:0]    r_k;
  logic [ADDR_W-1:0]   r_addr;

  logic                r_inf_valid;
  logic [SEL_W-1:0]    r_inf_sel;
  logic [IDX_W-1:0]    r_inf_idx;
  logic                r_inf_last;

  logic [DATA_W-1:0]   r_fifo_data [2];
  logic [IDX_W-1:0]    r_fifo_idx  [2];
  logic [1:0]          r_fifo_last;
  logic                r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_count;

  logic                w_pop, w_push, w_issue, w_k_last, w_drained;
  logic [1:0]          w_credit;
  logic [IDX_W:0]      w_n_clamped;
  logic [DATA_W-1:0]   w_rd_data;

  assign w_n_clamped = (num_elems > MaxN) ? MaxN : num_elems;
  assign w_pop       = out_valid && out_ready;
  assign w_push      = r_inf_valid;
  assign w_credit    = r_count + {1'b0, r_inf_valid};
  // A pop this cycle frees a slot in time for the read issued now, which keeps
  // one element per cycle flowing while the outstanding total stays at two.
  assign w_issue     = (r_state == StRun) && ((w_credit - {1'b0, w_pop}) < 2'd2);
  assign w_k_last    = ({1'b0, r_k} == (r_n - 1'b1));
  assign w_drained   = w_pop && out_last && (r_count == 2'd1) && !r_inf_valid;

  assign rd_addr   = w_issue ? r_k[SEL_W +: ADDR_W] : r_addr;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_fifo_data[r_rd_ptr];
  assign out_index = r_fifo_idx[r_rd_ptr];
  assign out_last  = r_fifo_last[r_rd_ptr];
  assign busy      = (r_state == StRun) || (r_state == StDrain);
  assign done      = (r_state == StDone);

  // Select the bank that was addressed by the in-flight read.
  always_comb begin
    w_rd_data = rd_data_1;
    case (r_inf_sel)
      2'd0:    w_rd_data = rd_data_1;
      2'd1:    w_rd_data = rd_data_2;
      2'd2:    w_rd_data = rd_data_3;
      default: w_rd_data = rd_data_4;
    endcase
  end

  // Next-state logic for the sweep controller.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (start) w_state_next = (num_elems == '0) ? StDone : StRun;
      StRun:   if (w_issue && w_k_last) w_state_next = StDrain;
      StDrain: if (w_drained) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State, element counter, address hold and in-flight read tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_n         <= '0;
      r_k         <= '0;
      r_addr      <= '0;
      r_inf_valid <= 1'b0;
      r_inf_sel   <= '0;
      r_inf_idx   <= '0;
      r_inf_last  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_inf_valid <= w_issue;
      if (r_state == StIdle && start) begin
        r_n <= w_n_clamped;
        r_k <= '0;
      end
      if (w_issue) begin
        r_addr     <= r_k[SEL_W +: ADDR_W];
        r_inf_sel  <= r_k[SEL_W-1:0];
        r_inf_idx  <= r_k;
        r_inf_last <= w_k_last;
        // k parks at N-1 so it never wraps past the final element.
        if (!w_k_last) r_k <= r_k + 1'b1;
      end
    end
  end

  // Two-entry output FIFO; capture one cycle after issue, pop on handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_idx[0]  <= '0;
      r_fifo_idx[1]  <= '0;
      r_fifo_last    <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_rd_data;
        r_fifo_idx[r_wr_ptr]  <= r_inf_idx;
        r_fifo_last[r_wr_ptr] <= r_inf_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_v_result_reader.sv
// Bench for v_result_reader: SRAM bank model, scoreboard fed at start time,
// and a negedge monitor that checks every handshake against the queue.
module tb_v_result_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] num_elems;
  logic [8:0]  rd_addr;
  logic [47:0] rd_data_1, rd_data_2, rd_data_3, rd_data_4;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] out_data;
  logic [10:0] out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  v_result_reader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .num_elems (num_elems),
    .rd_addr   (rd_addr),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2),
    .rd_data_3 (rd_data_3),
    .rd_data_4 (rd_data_4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Solved vector in global element order; bank b address a holds v[4a+b].
  logic [47:0] v [2048];

  always @(posedge clock) begin
    rd_data_1 <= v[{rd_addr, 2'd0}];
    rd_data_2 <= v[{rd_addr, 2'd1}];
    rd_data_3 <= v[{rd_addr, 2'd2}];
    rd_data_4 <= v[{rd_addr, 2'd3}];
  end

  typedef struct {
    logic [47:0] d;
    logic [10:0] i;
    logic        l;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream for a start with count n: elements 0..min(n,2048)-1.
  task automatic push_run(input int n);
    int m;
    m = (n > 2048) ? 2048 : n;
    for (int k = 0; k < m; k++) q.push_back('{v[k], 11'(k), (k == m - 1)});
  endtask

  // out_ready driver: 0 = always high, 1 = fixed pattern, 2 = random.
  int mode = 0;
  int pat_i = 0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  always begin
    @(posedge clock);
    #1;
    case (mode)
      1:       begin out_ready = pat[pat_i]; pat_i = (pat_i + 1) % 6; end
      2:       out_ready = ($urandom_range(3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: handshakes, stall stability and done timing.
  int          hs_cnt = 0;
  logic        exp_done = 1'b0;
  logic        zero_ok = 1'b0;
  logic        stall_v = 1'b0;
  logic [47:0] hold_d;
  logic [10:0] hold_i;
  logic        hold_l;
  always @(negedge clock) begin
    logic cur;
    exp_t e;
    if (reset) begin
      exp_done = 1'b0;
      stall_v  = 1'b0;
    end else begin
      cur      = exp_done;
      exp_done = 1'b0;
      if (stall_v) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_data_held", out_data, hold_d);
        chk("stall_index_held", out_index, hold_i);
        chk("stall_last_held", out_last, hold_l);
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_index", out_index, e.i);
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
          if (e.l) exp_done = 1'b1;
        end
      end
      stall_v = out_valid && !out_ready;
      hold_d  = out_data;
      hold_i  = out_index;
      hold_l  = out_last;
      if ((done || cur) && !zero_ok) chk("done_timing", done, cur);
    end
  end

  task automatic pulse_start(input logic [11:0] n);
    @(posedge clock);
    #1;
    start     = 1'b1;
    num_elems = n;
    @(posedge clock);
    #1;
    start     = 1'b0;
    num_elems = 12'($urandom);
  endtask

  task automatic wait_done(input int bound);
    int   cyc;
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < bound) begin
      @(negedge clock);
      cyc++;
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs0;
    int n;
    for (int k = 0; k < 2048; k++) v[k] = {1'b0, 11'(k), 12'h0, 24'($urandom)};
    reset     = 1'b1;
    start     = 1'b0;
    num_elems = '0;
    #1;
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // N=8, ready high: exact latency, addresses and throughput.
    mode = 0;
    push_run(8);
    pulse_start(12'd8);
    for (int j = 1; j <= 11; j++) begin
      @(negedge clock);
      if (j <= 8) chk("t1_rd_addr", rd_addr, (j - 1) / 4);
      chk("t1_out_valid", out_valid, (j >= 3 && j <= 10));
      chk("t1_busy", busy, (j <= 10));
      chk("t1_done", done, (j == 11));
    end
    chk("t1_queue_drained", q.size(), 0);

    // N=6 with a fixed backpressure pattern.
    mode  = 1;
    pat_i = 0;
    push_run(6);
    pulse_start(12'd6);
    wait_done(100);

    // N=0: immediate done, nothing streamed, never busy.
    mode    = 0;
    zero_ok = 1'b1;
    pulse_start(12'd0);
    @(negedge clock);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_valid", out_valid, 0);
    @(negedge clock);
    chk("t3_done_off", done, 0);
    chk("t3_busy_off", busy, 0);
    zero_ok = 1'b0;

    // Start re-pulsed while running is ignored.
    mode = 2;
    push_run(10);
    pulse_start(12'd10);
    repeat (4) @(posedge clock);
    #1;
    start     = 1'b1;
    num_elems = 12'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(200);

    // Clamp 12'hFFF to 2048 elements.
    hs0 = hs_cnt;
    push_run(12'hFFF);
    pulse_start(12'hFFF);
    wait_done(10000);
    chk("t5_handshakes", hs_cnt - hs0, 2048);

    // Random counts under random backpressure.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(40, 1);
      push_run(n);
      pulse_start(12'(n));
      wait_done(500);
    end

    // Asynchronous reset mid-run, then a fresh start from index 0.
    mode = 0;
    push_run(20);
    pulse_start(12'd20);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("t7_rd_addr", rd_addr, 0);
    chk("t7_out_valid", out_valid, 0);
    chk("t7_out_data", out_data, 0);
    chk("t7_out_index", out_index, 0);
    chk("t7_out_last", out_last, 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("t7_no_done", done, 0);
    push_run(4);
    pulse_start(12'd4);
    wait_done(100);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v_result_reader.md
Name: v_result_reader

Overview:
- Read-out engine for the solved V vector once the Jacobi solver asserts writeDoneFlag.
- Sweeps the four 48-bit V SRAM banks through their second read port in global element order and streams each complex value {real[47:24], imag[23:0]} on a valid/ready interface toward the output/dump logic.
- Two-entry output FIFO with read-credit control, so backpressure never loses an SRAM read.

Parameters:
- NUM_BANKS, 4, V SRAM banks; element k lives in bank k%4 at address k/4.
- ADDR_W, 9, per-bank address width (512 words).
- DATA_W, 48, complex word: 24-bit real MSBs, 24-bit imaginary LSBs.
- IDX_W, 11, element index width (max 2048 elements).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle pulse (writeDoneFlag rise); sampled only in IDLE.
- num_elems  input  12  element count, sampled with start; values above 2048 are clamped to 2048.
- rd_addr  output  9  broadcast to sram_1..4_addressline_2.
- rd_data_1 .. rd_data_4  input  48 each  bank readline_2 data; valid 1 cycle after address.
- out_valid  output  1  out_data / out_index / out_last are valid.
- out_ready  input  1  consumer accepts when valid&&ready at the clock edge.
- out_data  output  48  V element.
- out_index  output  11  global element index k.
- out_last  output  1  high with the final element.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset values: rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, FIFO empty, issue counter 0, state IDLE.
- States:
  - IDLE: start=1 with num_elems=0 goes to DONE, producing no outputs. start=1 with nonzero num_elems latches N=min(num_elems,2048), clears the issue counter k, and goes to RUN.
  - RUN: issues a read whenever (fifo_count + inflight) < 2. When an issue is made with k == N-1, the state goes to DRAIN.
  - DRAIN: no new issues. When the FIFO is empty, nothing is in flight, and the final handshake has occurred, the state goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Issue: rd_addr=k[10:2]. The bank select k[1:0] and index k go into a 1-deep in-flight register. k increments by 1 per issue.
- Capture: one cycle after issue, rd_data_{sel+1} is written into the FIFO with its index and last flag (k==N-1).
- The FIFO head drives out_*. Entries pop on out_valid&&out_ready. Push and pop in the same cycle are legal, and count is unchanged.
- Latency: start sampled at edge E0 → rd_addr=0 during the cycle after E0 → data captured at E2 → out_valid=1 after E2.
- Throughput: with out_ready held high, one element per cycle. N elements finish in N+2 cycles after E0, and done follows one cycle after the last accept.
- Backpressure: out_ready=0 stalls issue once the credit (FIFO count plus in-flight) reaches 2. No read is dropped or repeated. out_data/out_index/out_last are held stable while out_valid=1 and not accepted.
- rd_addr holds its last value when not issuing.
- start while busy is ignored. num_elems changes after sampling have no effect.
- Index wraps never: k stops at N-1. For N=2048, k ends at 2047 and rd_addr ends at 511, bank 3.
- Asynchronous reset mid-operation: immediate return to reset values. In-flight and FIFO data are discarded and done is not pulsed.

Test Plan:
- Bank words preloaded with value = {12'h0, index, 24'h0…} pattern; start with num_elems=8, out_ready=1 → indices 0..7, banks 0,1,2,3,0,1,2,3, rd_addr 0,0,0,0,1,1,1,1; out_valid continuous for 8 cycles starting 2 cycles after start; out_last only on index 7; done one cycle later.
- num_elems=6, out_ready toggled 1,0,0,1,0,1,… → all 6 elements delivered in order exactly once. Data stays stable while stalled. The FIFO never exceeds 2 entries and rd_addr never advances more than 2 elements beyond the last accepted one.
- num_elems=0 → no out_valid; done pulses the cycle after start; busy stays 0.
- num_elems=12'hFFF → clamped to 2048. The last element has index 2047 from bank 3 at address 511, with out_last=1. Exactly 2048 handshakes occur.
- start re-pulsed during RUN with num_elems=3 → ignored; the original count completes.
- reset asserted asynchronously mid-RUN (between edges) → outputs reach reset values immediately without waiting for a clock. A fresh start with num_elems=4 afterwards restarts at index 0.
